spi_target_regfile: RTL and testbench
=====================================

SPI_TARGET_REGFILE -- requirements
Module: spi_target_regfile

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, which sets register-file address width (16 entries).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, which sets register word width.
REQ-003 SHALL have one clock and an asynchronous active-low reset, as follows:
- clk_i  input  1  system clock, ≥8× spi_clk_i frequency
- rst_n_i  input  1  asynchronous active-low reset
REQ-004 SHALL have the following SPI port:
- spi_clk_i  input  1  SPI clock from master, mode 0 (CPOL=0, CPHA=0)
- spi_cs_n_i  input  1  chip select, active-low
- spi_sdi_i  input  1  serial data from master (master SDO)
- spi_sdo_o  output  1  serial data to master
- spi_sdo_oe_o  output  1  SDO output enable
REQ-005 SHALL have the following write-notify and local read port:
- wr_strobe_o  output  1  one-cycle pulse per completed SPI word write
- wr_addr_o  output  ADDR_WIDTH  address of that write
- wr_data_o  output  DATA_WIDTH  data of that write
- loc_addr_i  input  ADDR_WIDTH  local read address
- loc_rdata_o  output  DATA_WIDTH  registered mem[loc_addr_i], 1-cycle latency
- busy_o  output  1  high while a frame is in progress (synchronized CS asserted)

Function
REQ-006 SHALL pass spi_clk_i, spi_cs_n_i and spi_sdi_i through 2-flop synchronizers, then detect rising and falling spi_clk edges on the synchronized signal; latency from pin edge to detected edge is 3 clk_i cycles.
REQ-007 SHALL sample SDI on detected rising edges and update SDO on detected falling edges, MSB first.
REQ-008 SHALL define the frame as: 8-bit command, 8-bit address (low ADDR_WIDTH bits used), then N×DATA_WIDTH data bits.
REQ-009 SHALL use command 0x02 for write and 0x03 for read; any other value SHALL enter IGNORE.
REQ-010 SHALL implement the FSM states IDLE, CMD, ADDR, WR_DATA, RD_DATA and IGNORE.
REQ-011 SHALL make the following FSM transitions:
- IDLE→CMD on synchronized cs_n falling.
- CMD→ADDR after 8 bits.
- ADDR→WR_DATA or RD_DATA after 8 bits.
REQ-012 SHALL, in WR_DATA, write mem[addr] one clk_i cycle after the DATA_WIDTH-th bit is sampled, pulse wr_strobe_o for that same cycle with wr_addr_o/wr_data_o valid, then increment addr.
REQ-013 SHALL, on entry to RD_DATA, load mem[addr] into the TX shifter and drive bit DATA_WIDTH-1 on the falling edge following the last address bit.
REQ-014 SHALL, in RD_DATA, shift one bit out per falling edge; after DATA_WIDTH bits, increment addr and reload from mem[addr] at that falling edge, giving a gapless stream.
REQ-015 SHALL wrap address increments modulo 2^ADDR_WIDTH (0xF→0x0).
REQ-016 SHALL assert spi_sdo_oe_o only in RD_DATA with CS asserted; spi_sdo_o SHALL be 0 whenever spi_sdo_oe_o is low.
REQ-017 SHALL return to IDLE from any state on CS deassertion, discard any partial word without writing it or pulsing wr_strobe_o, and drop spi_sdo_oe_o in the same cycle.
REQ-018 SHALL, in IGNORE, keep SDO disabled and ignore all bits until CS deasserts.
REQ-019 SHALL, if a local read and an SPI write target the same address in the same cycle, return the old data on loc_rdata_o.

Reset
REQ-020 SHALL on reset set the FSM to IDLE, clear all mem entries to 0, clear all shifters, bit counters and addr, drive every output to 0 and set synchronizer flops to idle levels (cs_n=1, clk=0).
REQ-021 SHALL ignore any frame in progress across reset deassertion; decoding SHALL restart only after CS deasserts and reasserts.

Structure
REQ-022 SHALL place command opcodes, the FSM state enum and the default widths in package spi_target_pkg.
REQ-023 SHALL use a single sub-module spi_sync (2-flop synchronizer plus edge detector), instantiated for spi_clk_i and spi_cs_n_i; SDI SHALL use the sync stage only.

Verification
REQ-024 SHALL check single write: frame 0x02, 0x01, 0xABCD1234 → one wr_strobe_o pulse with wr_addr_o=1, wr_data_o=0xABCD1234, and loc_addr_i=1 then reads 0xABCD1234.
REQ-025 SHALL check read-back: after the REQ-024 write, frame 0x03, 0x01 with 32 clocks → master captures 0xABCD1234, and spi_sdo_oe_o is high only during the data phase.
REQ-026 SHALL check burst with wrap: write 0x02, 0x0F, 0x11111111, 0x22222222 → mem[15]=0x11111111 and mem[0]=0x22222222, with two strobes; a burst read from 0x0F returns the same two words.
REQ-027 SHALL check abort: CS deasserted after 20 of 32 data bits of a write to address 3 → no strobe and mem[3] unchanged (0).
REQ-028 SHALL check bad command: frame 0xFF, 0x02, 32 bits → no strobe, spi_sdo_oe_o stays 0, and busy_o falls after CS deasserts.
REQ-029 SHALL check reset mid-frame: rst_n_i pulsed low during a write data phase → all mem entries read 0, and a subsequent new frame completes normally.

Source files
------------

// File: rtl/spi_target_pkg.sv
//------------------------------------------------------------------------------
// spi_target_pkg : opcodes, FSM states and default widths for spi_target_regfile
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

package spi_target_pkg;

  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 32;

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_ADDR    = 3'd2,
    ST_WR_DATA = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_IGNORE  = 3'd5
  } state_e;

endpackage

`default_nettype wire

// File: rtl/spi_sync.sv
//------------------------------------------------------------------------------
// spi_sync : 2-flop synchronizer with rise/fall detection on the synced level
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

`default_nettype wire

// File: rtl/spi_target_regfile.sv
//------------------------------------------------------------------------------
// spi_target_regfile : SPI mode-0 target with burst read/write register file
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module spi_target_regfile
  import spi_target_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  spi_clk_i,
  input  logic                  spi_cs_n_i,
  input  logic                  spi_sdi_i,
  output logic                  spi_sdo_o,
  output logic                  spi_sdo_oe_o,
  output logic                  wr_strobe_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  input  logic [ADDR_WIDTH-1:0] loc_addr_i,
  output logic [DATA_WIDTH-1:0] loc_rdata_o,
  output logic                  busy_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CNT_W = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH) : 3;
  localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(7);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(DATA_WIDTH - 1);

  logic sclk_level_unused;
  logic sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic sdi_meta_q, sdi_q;

  spi_sync #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .async_i (spi_clk_i),
    .sync_o  (sclk_level_unused),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  spi_sync #(.RST_VAL(1'b1)) u_sync_cs (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .async_i (spi_cs_n_i),
    .sync_o  (cs_s),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d, rx_next;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic                  sdo_q, sdo_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_inc;
  logic                  is_rd_q, is_rd_d;
  logic                  wr_stb_q, wr_stb_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [1:0]            settle_q;
  logic                  armed_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] loc_rdata_q;

  assign rx_next  = {rx_q[DATA_WIDTH-2:0], sdi_q};
  assign addr_inc = addr_q + ADDR_WIDTH'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    sdo_d     = sdo_q;
    addr_d    = addr_q;
    is_rd_d   = is_rd_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (state_q != ST_IDLE && cs_rise) begin
      // CS release abandons any partial word
      state_d = ST_IDLE;
      cnt_d   = '0;
      rx_d    = '0;
      tx_d    = '0;
      sdo_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cs_fall && armed_q) begin
            state_d = ST_CMD;
            cnt_d   = '0;
            rx_d    = '0;
          end
        end
        ST_CMD: begin
          if (sclk_rise) begin
            rx_d  = rx_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == BYTE_LAST) begin
              cnt_d   = '0;
              is_rd_d = (rx_next[7:0] == CMD_READ);
              state_d = (rx_next[7:0] == CMD_WRITE || rx_next[7:0] == CMD_READ)
                        ? ST_ADDR : ST_IGNORE;
            end
          end
        end
        ST_ADDR: begin
          if (sclk_rise) begin
            rx_d  = rx_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == BYTE_LAST) begin
              cnt_d  = '0;
              addr_d = rx_next[ADDR_WIDTH-1:0];
              if (is_rd_q) begin
                state_d = ST_RD_DATA;
                tx_d    = mem_q[rx_next[ADDR_WIDTH-1:0]];
              end else begin
                state_d = ST_WR_DATA;
              end
            end
          end
        end
        ST_WR_DATA: begin
          if (sclk_rise) begin
            rx_d  = rx_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == WORD_LAST) begin
              cnt_d     = '0;
              wr_stb_d  = 1'b1;
              wr_addr_d = addr_q;
              wr_data_d = rx_next;
              addr_d    = addr_inc;
            end
          end
        end
        ST_RD_DATA: begin
          if (sclk_fall) begin
            sdo_d = tx_q[DATA_WIDTH-1];
            tx_d  = {tx_q[DATA_WIDTH-2:0], 1'b0};
            cnt_d = cnt_q + CNT_W'(1);
            // Reload on the last bit's falling edge so the next word follows gaplessly
            if (cnt_q == WORD_LAST) begin
              cnt_d  = '0;
              addr_d = addr_inc;
              tx_d   = mem_q[addr_inc];
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      sdo_q      <= 1'b0;
      addr_q     <= '0;
      is_rd_q    <= 1'b0;
      wr_stb_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      sdi_meta_q <= 1'b0;
      sdi_q      <= 1'b0;
      settle_q   <= '0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      sdo_q      <= sdo_d;
      addr_q     <= addr_d;
      is_rd_q    <= is_rd_d;
      wr_stb_q   <= wr_stb_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      sdi_meta_q <= spi_sdi_i;
      sdi_q      <= sdi_meta_q;
      // Arm only once the CS synchronizer holds the real pin level and it is idle
      if (settle_q != 2'd2) settle_q <= settle_q + 2'd1;
      if (settle_q == 2'd2 && cs_s) armed_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      loc_rdata_q <= '0;
    end else begin
      if (wr_stb_q) mem_q[wr_addr_q] <= wr_data_q;
      loc_rdata_q <= mem_q[loc_addr_i];
    end
  end

  assign spi_sdo_oe_o = (state_q == ST_RD_DATA) && !cs_s;
  assign spi_sdo_o    = spi_sdo_oe_o & sdo_q;
  assign wr_strobe_o  = wr_stb_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign loc_rdata_o  = loc_rdata_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_spi_target_regfile.sv
//------------------------------------------------------------------------------
// tb_spi_target_regfile : directed SPI master bench for spi_target_regfile
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_spi_target_regfile;

  localparam int HALF = 80;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        spi_clk_i = 1'b0;
  logic        spi_cs_n_i = 1'b1;
  logic        spi_sdi_i = 1'b0;
  logic        spi_sdo_o;
  logic        spi_sdo_oe_o;
  logic        wr_strobe_o;
  logic [3:0]  wr_addr_o;
  logic [31:0] wr_data_o;
  logic [3:0]  loc_addr_i = 4'd0;
  logic [31:0] loc_rdata_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;
  int stb_cnt = 0;
  logic [3:0]  stb_addr = 4'd0;
  logic [31:0] stb_data = 32'd0;

  spi_target_regfile #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .spi_clk_i    (spi_clk_i),
    .spi_cs_n_i   (spi_cs_n_i),
    .spi_sdi_i    (spi_sdi_i),
    .spi_sdo_o    (spi_sdo_o),
    .spi_sdo_oe_o (spi_sdo_oe_o),
    .wr_strobe_o  (wr_strobe_o),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o),
    .loc_addr_i   (loc_addr_i),
    .loc_rdata_o  (loc_rdata_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (wr_strobe_o) begin
      stb_cnt  = stb_cnt + 1;
      stb_addr = wr_addr_o;
      stb_data = wr_data_o;
    end
  end

  // Shift nbits of w out MSB first; capture SDO and OE at each rising SCLK
  task automatic spi_word(input logic [31:0] w, input int nbits,
                          output logic [31:0] r, output int oe_hi);
    r = '0;
    oe_hi = 0;
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_sdi_i = w[i];
      #(HALF);
      spi_clk_i = 1'b1;
      r = {r[30:0], spi_sdo_o};
      if (spi_sdo_oe_o) oe_hi++;
      #(HALF);
      spi_clk_i = 1'b0;
    end
  endtask

  task automatic cs_start();
    @(negedge clk_i);
    spi_cs_n_i = 1'b0;
    #(HALF);
  endtask

  task automatic cs_end();
    #(HALF);
    spi_cs_n_i = 1'b1;
    repeat (10) @(negedge clk_i);
  endtask

  task automatic loc_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk_i);
    loc_addr_i = a;
    @(negedge clk_i);
    d = loc_rdata_o;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_n_i = 1'b0;
    repeat (4) @(negedge clk_i);
    checks++;
    if ({wr_strobe_o, wr_addr_o, wr_data_o, loc_rdata_o, busy_o, spi_sdo_o, spi_sdo_oe_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got strb=%b addr=%h data=%h rd=%h busy=%b sdo=%b oe=%b exp all 0",
               wr_strobe_o, wr_addr_o, wr_data_o, loc_rdata_o, busy_o, spi_sdo_o, spi_sdo_oe_o);
    end
    rst_n_i = 1'b1;
    repeat (5) @(negedge clk_i);
    loc_read(4'd9, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_mem9 got %h exp 00000000", d); end
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
  endtask

  task automatic test_single_write();
    logic [31:0] r, d;
    int oe, s0;
    s0 = stb_cnt;
    cs_start();
    spi_word(32'h02, 8, r, oe);
    repeat (4) @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL write_busy got %b exp 1", busy_o); end
    spi_word(32'h01, 8, r, oe);
    spi_word(32'hABCD1234, 32, r, oe);
    cs_end();
    checks++;
    if (stb_cnt - s0 !== 1) begin errors++; $display("FAIL write_strobes got %0d exp 1", stb_cnt - s0); end
    checks++;
    if (stb_addr !== 4'h1) begin errors++; $display("FAIL write_addr got %h exp 1", stb_addr); end
    checks++;
    if (stb_data !== 32'hABCD1234) begin errors++; $display("FAIL write_data got %h exp abcd1234", stb_data); end
    loc_read(4'd1, d);
    checks++;
    if (d !== 32'hABCD1234) begin errors++; $display("FAIL write_locread got %h exp abcd1234", d); end
  endtask

  task automatic test_read_back();
    logic [31:0] r;
    int oe_a, oe_b, oe_d;
    cs_start();
    spi_word(32'h03, 8, r, oe_a);
    spi_word(32'h01, 8, r, oe_b);
    checks++;
    if (oe_a + oe_b !== 0) begin errors++; $display("FAIL read_oe_header got %0d exp 0", oe_a + oe_b); end
    spi_word(32'h0, 32, r, oe_d);
    checks++;
    if (r !== 32'hABCD1234) begin errors++; $display("FAIL read_data got %h exp abcd1234", r); end
    checks++;
    if (oe_d !== 32) begin errors++; $display("FAIL read_oe_data got %0d exp 32", oe_d); end
    cs_end();
    checks++;
    if ({spi_sdo_oe_o, spi_sdo_o} !== 2'b00) begin
      errors++; $display("FAIL read_oe_after got %b%b exp 00", spi_sdo_oe_o, spi_sdo_o);
    end
  endtask

  task automatic test_burst_wrap();
    logic [31:0] r, d;
    int oe, s0;
    s0 = stb_cnt;
    cs_start();
    spi_word(32'h02, 8, r, oe);
    spi_word(32'h0F, 8, r, oe);
    spi_word(32'h11111111, 32, r, oe);
    spi_word(32'h22222222, 32, r, oe);
    cs_end();
    checks++;
    if (stb_cnt - s0 !== 2) begin errors++; $display("FAIL burst_strobes got %0d exp 2", stb_cnt - s0); end
    loc_read(4'hF, d);
    checks++;
    if (d !== 32'h11111111) begin errors++; $display("FAIL burst_mem15 got %h exp 11111111", d); end
    loc_read(4'h0, d);
    checks++;
    if (d !== 32'h22222222) begin errors++; $display("FAIL burst_mem0 got %h exp 22222222", d); end
    cs_start();
    spi_word(32'h03, 8, r, oe);
    spi_word(32'h0F, 8, r, oe);
    spi_word(32'h0, 32, r, oe);
    checks++;
    if (r !== 32'h11111111) begin errors++; $display("FAIL burst_rd0 got %h exp 11111111", r); end
    spi_word(32'h0, 32, r, oe);
    checks++;
    if (r !== 32'h22222222) begin errors++; $display("FAIL burst_rd1 got %h exp 22222222", r); end
    cs_end();
  endtask

  task automatic test_abort();
    logic [31:0] r, d;
    int oe, s0;
    s0 = stb_cnt;
    cs_start();
    spi_word(32'h02, 8, r, oe);
    spi_word(32'h03, 8, r, oe);
    spi_word(32'hFFFFF, 20, r, oe);
    cs_end();
    checks++;
    if (stb_cnt - s0 !== 0) begin errors++; $display("FAIL abort_strobes got %0d exp 0", stb_cnt - s0); end
    loc_read(4'd3, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL abort_mem3 got %h exp 00000000", d); end
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy_o); end
  endtask

  task automatic test_bad_cmd();
    logic [31:0] r;
    int oe_a, oe_b, oe_d, s0;
    s0 = stb_cnt;
    cs_start();
    spi_word(32'hFF, 8, r, oe_a);
    spi_word(32'h02, 8, r, oe_b);
    spi_word(32'hDEADBEEF, 32, r, oe_d);
    #(HALF);
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL badcmd_busy_in got %b exp 1", busy_o); end
    spi_cs_n_i = 1'b1;
    repeat (10) @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL badcmd_busy_out got %b exp 0", busy_o); end
    checks++;
    if (oe_a + oe_b + oe_d !== 0) begin errors++; $display("FAIL badcmd_oe got %0d exp 0", oe_a + oe_b + oe_d); end
    checks++;
    if (stb_cnt - s0 !== 0) begin errors++; $display("FAIL badcmd_strobes got %0d exp 0", stb_cnt - s0); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] r, d;
    int oe, s0;
    s0 = stb_cnt;
    cs_start();
    spi_word(32'h02, 8, r, oe);
    spi_word(32'h05, 8, r, oe);
    spi_word(32'h3FF, 10, r, oe);
    @(negedge clk_i);
    rst_n_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (10) @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy_o); end
    spi_word(32'h3FFFFF, 22, r, oe);
    cs_end();
    checks++;
    if (stb_cnt - s0 !== 0) begin errors++; $display("FAIL rstmid_strobes got %0d exp 0", stb_cnt - s0); end
    for (int a = 0; a < 16; a++) begin
      loc_read(4'(a), d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL rstmid_mem%0d got %h exp 00000000", a, d); end
    end
    s0 = stb_cnt;
    cs_start();
    spi_word(32'h02, 8, r, oe);
    spi_word(32'h07, 8, r, oe);
    spi_word(32'h5A5AA5A5, 32, r, oe);
    cs_end();
    checks++;
    if (stb_cnt - s0 !== 1 || stb_addr !== 4'h7 || stb_data !== 32'h5A5AA5A5) begin
      errors++;
      $display("FAIL rstmid_newframe got n=%0d addr=%h data=%h exp n=1 addr=7 data=5a5aa5a5",
               stb_cnt - s0, stb_addr, stb_data);
    end
    loc_read(4'd7, d);
    checks++;
    if (d !== 32'h5A5AA5A5) begin errors++; $display("FAIL rstmid_mem7 got %h exp 5a5aa5a5", d); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_back();
    test_burst_wrap();
    test_abort();
    test_bad_cmd();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
